// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_ZERO   = 0;
    localparam int WAIT_CNT_W = 8;

    // Controller states, kept as plain encoded constants for legacy tools.
    typedef logic [1:0] hazardState_t;
    localparam hazardState_t RUN      = 2'd0;
    localparam hazardState_t FLUSH    = 2'd1;
    localparam hazardState_t MEM_WAIT = 2'd2;

endpackage

// File: rtl/hazard_control_unit_load_use_detector.sv
// Combinational load-use compare between the EX load destination and the ID sources.
module load_use_detector
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              EX_MemRead,
    input  logic [ADDR_W-1:0] EX_WriteRegister,
    input  logic [ADDR_W-1:0] ID_rs,
    input  logic [ADDR_W-1:0] ID_rt,
    input  logic              ID_uses_rt,
    output logic              loadUse
);

    logic destValid;
    logic rsMatch;
    logic rtMatch;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign destValid = EX_MemRead && (EX_WriteRegister != ADDR_W'(REG_ZERO));
    assign rsMatch   = (EX_WriteRegister == ID_rs);
    assign rtMatch   = ID_uses_rt && (EX_WriteRegister == ID_rt);
    assign loadUse   = destValid && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/bubble/flush controller for load-use, taken-branch and data-memory-wait hazards.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  ID_uses_rt,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_WriteRegister,
    input  logic                  EX_branch_taken,
    input  logic                  MEM_req,
    input  logic                  mem_ready,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  stall_idex,
    output logic                  stall_exmem,
    output logic                  bubble_idex,
    output logic                  bubble_memwb,
    output logic                  flush_ifid,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

    hazardState_t          state;
    hazardState_t          nextState;
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic [WAIT_CNT_W-1:0] nextWaitCnt;
    logic                  loadUse;
    logic                  memWait;
    logic                  holdMem;
    logic                  doFlush;
    logic                  doLu;
    logic                  setError;
    logic                  active;

    load_use_detector #(.ADDR_W(REG_ADDR_W)) u_luDetect (
        .EX_MemRead       (EX_MemRead),
        .EX_WriteRegister (EX_WriteRegister),
        .ID_rs            (ID_rs),
        .ID_rt            (ID_rt),
        .ID_uses_rt       (ID_uses_rt),
        .loadUse          (loadUse)
    );

    assign memWait = MEM_req && !mem_ready;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        holdMem     = 1'b0;
        doFlush     = 1'b0;
        doLu        = 1'b0;
        setError    = 1'b0;
        case (state)
            MEM_WAIT: begin
                if (!memWait) begin
                    if (EX_branch_taken) begin
                        doFlush   = 1'b1;
                        nextState = FLUSH;
                    end else begin
                        doLu      = loadUse;
                        nextState = RUN;
                    end
                end else if (waitCnt == WAIT_LIMIT) begin
                    setError  = 1'b1;
                    nextState = RUN;
                end else begin
                    holdMem     = 1'b1;
                    nextWaitCnt = waitCnt + 1'b1;
                end
            end
            FLUSH: begin
                // ID holds a squashed slot here, so LU is deliberately not evaluated.
                if (memWait) begin
                    holdMem     = 1'b1;
                    nextWaitCnt = WAIT_CNT_W'(1);
                    nextState   = MEM_WAIT;
                end else if (EX_branch_taken) begin
                    doFlush   = 1'b1;
                    nextState = FLUSH;
                end else begin
                    nextState = RUN;
                end
            end
            default: begin
                if (memWait) begin
                    holdMem     = 1'b1;
                    nextWaitCnt = WAIT_CNT_W'(1);
                    nextState   = MEM_WAIT;
                end else if (EX_branch_taken) begin
                    doFlush   = 1'b1;
                    nextState = FLUSH;
                end else begin
                    doLu      = loadUse;
                    nextState = RUN;
                end
            end
        endcase
    end

    // Controls are forced low for the whole time rst is high, not just after the next edge.
    assign active       = !rst;
    assign stall_pc     = active && (holdMem || doLu);
    assign stall_ifid   = active && (holdMem || doLu);
    assign stall_idex   = active && holdMem;
    assign stall_exmem  = active && holdMem;
    assign bubble_idex  = active && (doFlush || doLu);
    assign bubble_memwb = active && holdMem;
    assign flush_ifid   = active && doFlush;

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            waitCnt   <= '0;
            mem_error <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (setError) begin
                mem_error <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_pc && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (flush_ifid && (flushCnt != '1)) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign stall_cycles = stallCnt;
    assign flush_count  = flushCnt;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage pipelined processor. It sits beside the forwarding logic and handles the hazards that forwarding cannot resolve: load-use dependencies, taken-branch squashes and multi-cycle data-memory waits. It drives the stall, bubble and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also runs a watchdog on memory waits.

## Interface
- REG_ADDR_W, 4: register address width (16 registers; register 0 is never a hazard source).
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before abort; range 1..255.
- CNT_W, 16: performance counter width.

- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- ID_rs  in  REG_ADDR_W  source register rs of the instruction in ID.
- ID_rt  in  REG_ADDR_W  source register rt of the instruction in ID.
- ID_uses_rt  in  1  1 if the ID instruction reads rt.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_WriteRegister  in  REG_ADDR_W  destination register of the EX instruction.
- EX_branch_taken  in  1  a branch resolved taken in EX this cycle.
- MEM_req  in  1  the MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_pc  out  1  hold the PC.
- stall_ifid  out  1  hold IF/ID.
- stall_idex  out  1  hold ID/EX.
- stall_exmem  out  1  hold EX/MEM.
- bubble_idex  out  1  load a NOP into ID/EX.
- bubble_memwb  out  1  load a NOP into MEM/WB.
- flush_ifid  out  1  clear IF/ID.
- mem_error  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  count of stalled cycles (see Configuration).
- flush_count  out  CNT_W  count of taken-branch flushes (see Configuration).

## Operation
- FSM states: RUN, FLUSH, MEM_WAIT. Reset state is RUN.
- Load-use hazard (LU) is defined as: EX_MemRead, EX_WriteRegister != 0, and either EX_WriteRegister == ID_rs or (ID_uses_rt and EX_WriteRegister == ID_rt).
- Memory wait (MW) is defined as: MEM_req and not mem_ready.
- Priority in RUN, evaluated per cycle, first match wins:
  - MW: assert stall_pc, stall_ifid, stall_idex, stall_exmem and bubble_memwb. Load the wait counter with 1. Go to MEM_WAIT. Branch and LU are ignored, because EX is frozen.
  - EX_branch_taken: assert flush_ifid and bubble_idex with no stall. Go to FLUSH. LU is ignored because the dependent instruction is squashed.
  - LU: assert stall_pc, stall_ifid and bubble_idex. Stay in RUN.
  - Otherwise, all controls are 0.
- FLUSH lasts one cycle and masks LU, because ID holds a squashed slot. MW still wins and goes to MEM_WAIT. A new EX_branch_taken re-flushes and stays in FLUSH. Otherwise go to RUN.
- MEM_WAIT behaviour:
  - While MW holds, keep the four stalls and bubble_memwb asserted, and increment the wait counter.
  - On mem_ready, release the MEM-wait controls. In that same cycle, apply the RUN rules for branch and LU, then go to RUN or FLUSH.
  - If the wait counter reaches MEM_TIMEOUT with MW still true, set mem_error, release all stalls that cycle and go to RUN.
  - mem_error clears only on rst.
- All control outputs are combinational from the state and inputs. The state, wait counter, mem_error and counters are registered.

## Timing
- Reset values: state RUN, wait counter 0, mem_error 0, counters 0. All control outputs are 0 while rst is high.
- Controls take effect in the same cycle as the detecting inputs, so the pipeline registers act on the next clk edge.
- LU costs exactly one bubble. In the next cycle EX holds the bubble, so LU deasserts.
- A taken branch costs two squashed slots: IF/ID and ID/EX.
- A memory access with mem_ready arriving N cycles after MEM_req produces N stall cycles. mem_ready in the first cycle produces 0 stall cycles.
- If rst asserts during MEM_WAIT, the block returns to RUN immediately and all stalls drop asynchronously.

## Configuration
- Macro HAZARD_PERF_CNT_EN.
  - Defined: stall_cycles increments on every cycle where stall_pc = 1. flush_count increments on every cycle where flush_ifid = 1. Both saturate at all-ones.
  - Undefined: both ports remain but are tied to 0, and no counter flops are built.

## Structure
- Package hazard_pkg holds:
  - the state enum (RUN, FLUSH, MEM_WAIT);
  - REG_ADDR_W;
  - the constant REG_ZERO = 0;
  - the wait-counter width of 8 bits.
- One sub-module, load_use_detector, contains the combinational LU compare (address-equality and nonzero checks). It is instantiated once.

## Test plan
- EX load to r5, ID_rs = r5 -> one cycle with stall_pc = stall_ifid = bubble_idex = 1, then all controls 0. With EX_WriteRegister = 0, no stall.
- EX load to r3, ID_rt = r3, ID_uses_rt = 0 -> no stall. With ID_uses_rt = 1 -> one-cycle stall.
- EX_branch_taken together with LU -> flush_ifid = bubble_idex = 1 and stall_pc = 0. Next cycle is FLUSH, and LU stimulus there produces no stall.
- MEM_req with mem_ready arriving on the 4th cycle -> 3 cycles of four stalls plus bubble_memwb. A branch taken in the release cycle flushes. stall_cycles = 3 with the macro defined.
- MEM_TIMEOUT = 5 with mem_ready held at 0 -> mem_error rises on the 5th wait cycle, stalls drop, and mem_error stays 1 until rst.
- rst pulse in the middle of MEM_WAIT -> all outputs 0 immediately. The next MW re-enters MEM_WAIT with the wait counter restarted at 1.
